// File: rtl/rom_stream_reader.sv
// Strided read sequencer for a 1-cycle-latency ROM port, presenting the words as a
// valid/ready stream through a 2-entry buffer so backpressure never drops data.
module rom_stream_reader #(
  parameter int ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDRESS_WIDTH-1:0]     base,
  input  logic [ADDRESS_WIDTH-1:0]     stride,
  input  logic [ADDRESS_WIDTH:0]       count,
  output logic                         rom_en,
  output logic [ADDRESS_WIDTH-1:0]     rom_addr,
  input  logic signed [DATA_WIDTH-1:0] rom_do,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                        state;
  logic [ADDRESS_WIDTH-1:0]      stride_q;
  logic [ADDRESS_WIDTH:0]        count_q;
  logic [ADDRESS_WIDTH:0]        issued;
  logic                          inflight;
  logic                          inflight_last;
  logic signed [DATA_WIDTH-1:0]  mem_data [2];
  logic                          mem_last [2];
  logic                          rd_ptr;
  logic                          wr_ptr;
  logic [1:0]                    buf_count;
  logic [2:0]                    occ;
  logic                          pop;
  logic                          issue_last;

  // Stream handshake: a word transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid/out_data/out_last hold until that transfer.
  assign pop        = out_valid && out_ready;
  assign out_valid  = (buf_count != 2'd0);
  assign out_data   = mem_data[rd_ptr];
  assign out_last   = out_valid && mem_last[rd_ptr];
  assign issue_last = (issued == count_q - 1'b1);
  assign state_dbg  = state;

  // Slots the buffer will hold after this edge; an issue now lands one edge later.
  assign occ    = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign rom_en = (state == RUN) && (occ < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      stride_q      <= '0;
      count_q       <= '0;
      issued        <= '0;
      rom_addr      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      mem_data[0]   <= '0;
      mem_data[1]   <= '0;
      mem_last[0]   <= 1'b0;
      mem_last[1]   <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      buf_count     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= rom_en;
      inflight_last <= rom_en && issue_last;
      if (inflight) begin
        mem_data[wr_ptr] <= rom_do;
        mem_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_count <= buf_count + 2'(inflight) - 2'(pop);

      case (state)
        IDLE: begin
          if (start) begin
            stride_q <= stride;
            count_q  <= count;
            issued   <= '0;
            rom_addr <= base;
            if (count != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rom_en) begin
            rom_addr <= rom_addr + stride_q;
            issued   <= issued + 1'b1;
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Only the final word carries out_last, so its pop empties the pipeline.
          if (pop && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: ROM image model, scoreboard of expected stream words,
// directed sequences plus randomized base/stride/count/backpressure.
module tb_rom_stream_reader;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] stride;
  logic [AW:0]   count;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_do;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  rom_stream_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .stride(stride), .count(count),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_do(rom_do),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom_img [128];
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;
  int exp_done = 0;
  int done_total = 0;
  int en_cnt, pop_cnt, first_en, last_en, first_pop, last_pop, first_valid, s_cyc;
  int issued_tot = 0;
  int popped_tot = 0;

  // Synchronous-read ROM, one cycle of latency.
  always @(posedge clk) if (rom_en) rom_do <= rom_img[rom_addr];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Backpressure driver.
  initial begin
    int pidx = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = pat[pidx];
          pidx = (pidx + 1) % 6;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and tracks buffer occupancy.
  initial forever begin
    logic [W-1:0] e;
    @(negedge clk);
    if (rst) begin
      issued_tot = 0;
      popped_tot = 0;
    end else begin
      if (rom_en) begin
        check("occupancy_le_2", 32'(issued_tot - popped_tot <= 2), 1);
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        addr_log.push_back(rom_addr);
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got data 0x%0h last %0b, expected no word", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[DW-1:0]));
          check("out_last", 32'(out_last), 32'(e[DW]));
        end
      end
      if (done) done_total++;
      if (rom_en) issued_tot++;
      if (out_valid && out_ready) popped_tot++;
    end
  end

  task automatic clear_stats();
    en_cnt = 0; pop_cnt = 0; first_en = -1; last_en = -1;
    first_pop = -1; last_pop = -1; first_valid = -1;
    addr_log.delete();
  endtask

  task automatic push_model(input int b, input int s, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'(i == n - 1), rom_img[(b + i * s) % 128]});
  endtask

  // Called at posedge+1; returns at posedge+1 of the done cycle.
  task automatic run_seq(input int b, input int s, input int n, input bit repulse);
    bit got_done = 0;
    clear_stats();
    base = AW'(b); stride = AW'(s); count = (AW+1)'(n); start = 1'b1;
    s_cyc = cyc;
    push_model(b, s, n);
    exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
    base = AW'($urandom); stride = AW'($urandom); count = (AW+1)'($urandom_range(1, 9));
    check("busy_after_start", 32'(busy), 32'(n != 0));
    for (int k = 0; k < 3000; k++) begin
      if (done) begin got_done = 1; break; end
      if (repulse && k == 3) begin
        count = 8'd5; base = 7'd99; start = 1'b1;
      end
      if (repulse && k == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    if (!got_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected done within 3000 cycles (count %0d)", n);
    end else begin
      check("drained", 32'(exp_q.size()), 0);
      check("rom_en_count", 32'(en_cnt), 32'(n));
      if (n == 0) begin
        check("zero_done_latency", 32'(cyc - s_cyc), 1);
        check("zero_no_valid", 32'(first_valid), 32'(-1));
      end else begin
        check("done_after_last", 32'(cyc - last_pop), 1);
        check("issue_latency", 32'(first_en - s_cyc), 1);
        check("valid_latency", 32'(first_valid - s_cyc), 3);
      end
    end
  endtask

  initial begin
    int d0, b, s, n;
    rst = 1'b1; start = 1'b0; base = '0; stride = '0; count = '0;
    for (int i = 0; i < 128; i++) rom_img[i] = DW'($urandom);
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_en", 32'(rom_en), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(state_dbg), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Sequential addresses, full throughput.
    ready_mode = 0;
    run_seq(0, 1, 8, 0);
    check("t1_rom_en_back_to_back", 32'(last_en - first_en), 7);
    check("t1_out_back_to_back", 32'(last_pop - first_pop), 7);
    check("t1_pop_count", 32'(pop_cnt), 8);
    repeat (2) @(posedge clk); #1;

    // Address wrap.
    run_seq(120, 3, 4, 0);
    check("t2_addr_count", 32'(addr_log.size()), 4);
    check("t2_addr0", 32'(addr_log[0]), 120);
    check("t2_addr1", 32'(addr_log[1]), 123);
    check("t2_addr2", 32'(addr_log[2]), 126);
    check("t2_addr3", 32'(addr_log[3]), 1);
    repeat (2) @(posedge clk); #1;

    // Backpressure pattern.
    ready_mode = 1;
    run_seq(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), 5, 0);
    check("t3_pop_count", 32'(pop_cnt), 5);
    ready_mode = 0;
    repeat (2) @(posedge clk); #1;

    // Empty sequence.
    run_seq(33, 7, 0, 0);
    check("t4_busy_low", 32'(busy), 0);
    repeat (2) @(posedge clk); #1;

    // Start ignored while running, then chained start in the done cycle.
    run_seq(10, 2, 12, 1);
    run_seq(50, 5, 6, 0);
    repeat (2) @(posedge clk); #1;

    // Reset mid-sequence.
    clear_stats();
    base = 7'd20; stride = 7'd9; count = 8'd10; start = 1'b1;
    push_model(20, 9, 10);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200 && pop_cnt < 3; k++) begin
      @(posedge clk); #1;
    end
    check("t6_three_out", 32'(pop_cnt), 3);
    #2 rst = 1'b1;
    #1;
    check("t6_rom_en", 32'(rom_en), 0);
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_out_last", 32'(out_last), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    exp_q.delete();
    d0 = done_total;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("t6_no_done", 32'(done_total), 32'(d0));
    check("t6_idle_valid", 32'(out_valid), 0);
    run_seq(7, 11, 6, 0);
    repeat (2) @(posedge clk); #1;

    // Randomized sequences.
    for (int it = 0; it < 25; it++) begin
      ready_mode = int'($urandom_range(0, 2));
      b = int'($urandom_range(0, 127));
      s = int'($urandom_range(0, 127));
      n = (it == 0) ? 128 : int'($urandom_range(0, 20));
      run_seq(b, s, n, 0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    repeat (3) @(posedge clk); #1;

    check("final_queue_empty", 32'(exp_q.size()), 0);
    check("final_done_count", 32'(done_total), 32'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
